// File: rtl/seg_bcd_conv.sv
// Iterative double-dabble binary to 8-digit packed BCD with decimal-point mask for the 7-segment driver.
// Latency BIN_W+1 cycles from accepted start to done; start is ignored while busy, nothing is queued.
// Optional SEG_BCD_OVF_HEX_EN: overflow shows "EEEEEEEE" with no decimal point instead of saturating.
module seg_bcd_conv #(
    parameter int BIN_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    input  logic [2:0]       dp_pos,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [31:0]      data_out,
    output logic [7:0]       dp_ctrl
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0] MAX_DEC = 32'd99_999_999;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [BIN_W-1:0] bin_sh;
    logic [31:0]      bcd;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       dp_l;
    logic             ovf_l;

    logic [31:0]      bcd_adj;
    logic [31:0]      bcd_nxt;
    logic             ovf_in;
    logic [7:0]       dp_mask;

    // Zero-extend so the compare stays meaningful for narrow BIN_W.
    assign ovf_in  = {{(32-BIN_W){1'b0}}, bin_in} > MAX_DEC;
    assign dp_mask = (dp_l == 3'd0) ? 8'h00 : (8'h01 << dp_l);
    assign bcd_nxt = {bcd_adj[30:0], bin_sh[BIN_W-1]};

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bin_sh   <= '0;
            bcd      <= '0;
            cnt      <= '0;
            dp_l     <= '0;
            ovf_l    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            data_out <= '0;
            dp_ctrl  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sh <= bin_in;
                        dp_l   <= dp_pos;
                        ovf_l  <= ovf_in;
                        bcd    <= '0;
                        cnt    <= CNT_W'(BIN_W);
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd    <= bcd_nxt;
                    bin_sh <= {bin_sh[BIN_W-2:0], 1'b0};
                    cnt    <= cnt - CNT_W'(1);
                    // Final iteration: publish all result fields together.
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ovf   <= ovf_l;
                        if (ovf_l) begin
`ifdef SEG_BCD_OVF_HEX_EN
                            data_out <= 32'hEEEE_EEEE;
                            dp_ctrl  <= 8'h00;
`else
                            data_out <= 32'h9999_9999;
                            dp_ctrl  <= dp_mask;
`endif
                        end else begin
                            data_out <= bcd_nxt;
                            dp_ctrl  <= dp_mask;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_bcd_conv.sv
// Randomized self-checking bench for seg_bcd_conv against an arithmetic decimal-digit model.
module tb_seg_bcd_conv;

    localparam int BIN_W = 27;
    localparam int LAT   = BIN_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic [2:0]       dp_pos;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [31:0]      data_out;
    logic [7:0]       dp_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    seg_bcd_conv #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .dp_pos   (dp_pos),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .data_out (data_out),
        .dp_ctrl  (dp_ctrl)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Decimal digits by division, packed most significant digit leftmost.
    function automatic logic [31:0] ref_digits(input longint v);
        logic [31:0] r;
        longint      x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_data(input longint v);
        if (v > 99_999_999) begin
`ifdef SEG_BCD_OVF_HEX_EN
            return 32'hEEEE_EEEE;
`else
            return 32'h9999_9999;
`endif
        end
        return ref_digits(v);
    endfunction

    function automatic logic [7:0] ref_dp(input longint v, input int dp);
`ifdef SEG_BCD_OVF_HEX_EN
        if (v > 99_999_999) return 8'h00;
`endif
        if (dp == 0) return 8'h00;
        return 8'(1 << dp);
    endfunction

    // Starts a conversion in the current cycle and returns in the done cycle, so a
    // following call starts back-to-back. poke_cyc injects a start while busy.
    task automatic convert(input logic [BIN_W-1:0] v, input logic [2:0] dp, input string tag,
                           input int poke_cyc, input logic [BIN_W-1:0] poke_val,
                           output logic [31:0] res);
        int          cyc;
        bit          seen;
        int          bad;
        logic [31:0] prev_dat;
        logic [7:0]  prev_dp;
        logic        prev_ovf;
        start    = 1'b1;
        bin_in   = v;
        dp_pos   = dp;
        prev_dat = data_out;
        prev_dp  = dp_ctrl;
        prev_ovf = ovf;
        cyc      = 0;
        seen     = 0;
        while (!seen && cyc < LAT + 12) begin
            tick();
            cyc++;
            start  = (cyc == poke_cyc);
            bin_in = (cyc == poke_cyc) ? poke_val : BIN_W'($urandom);
            dp_pos = 3'($urandom);
            if (done) begin
                seen = 1;
            end else begin
                check({tag, " busy"}, 32'(busy), 32'd1);
                check({tag, " hold_dat"}, data_out, prev_dat);
                check({tag, " hold_dp"}, 32'(dp_ctrl), 32'(prev_dp));
                check({tag, " hold_ovf"}, 32'(ovf), 32'(prev_ovf));
            end
        end
        check({tag, " latency"}, cyc, LAT);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " data"}, data_out, ref_data(longint'(v)));
        check({tag, " dp"}, 32'(dp_ctrl), 32'(ref_dp(longint'(v), int'(dp))));
        check({tag, " ovf"}, 32'(ovf), 32'(longint'(v) > 99_999_999));
        if (longint'(v) <= 99_999_999) begin
            bad = 0;
            for (int i = 0; i < 8; i++)
                if (data_out[4*i +: 4] > 4'd9) bad++;
            check({tag, " nibbles"}, bad, 0);
        end
        res = data_out;
    endtask

    initial begin
        logic [31:0] res;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        dp_pos = '0;
        tick();
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst data", data_out, 32'h0);
        check("rst dp", 32'(dp_ctrl), 32'h0);
        rst = 1'b0;
        tick();

        convert(27'd0, 3'd0, "zero", -1, '0, res);
        check("zero lit", res, 32'h0000_0000);
        tick();
        check("done width", 32'(done), 32'd0);

        convert(27'd12_345_678, 3'd3, "d1", -1, '0, res);
        check("d1 lit", res, 32'h1234_5678);
        check("d1 dp lit", 32'(dp_ctrl), 32'h08);
        convert(27'd99_999_999, 3'd7, "d2", -1, '0, res);
        check("d2 lit", res, 32'h9999_9999);
        check("d2 dp lit", 32'(dp_ctrl), 32'h80);
        convert(27'd100_000_000, 3'd2, "ovf1", -1, '0, res);
        check("ovf1 flag", 32'(ovf), 32'd1);
        convert(27'd134_217_727, 3'd5, "ovf2", -1, '0, res);
        check("ovf2 flag", 32'(ovf), 32'd1);

        // Ignored start while busy, then a start held on the done cycle.
        tick();
        convert(27'd5, 3'd0, "ign", 10, 27'd7, res);
        check("ign lit", res, 32'h0000_0005);
        convert(27'd42, 3'd1, "b2b", -1, '0, res);
        check("b2b lit", res, 32'h0000_0042);

        // Reset mid-conversion.
        convert(27'd1234, 3'd0, "pre", -1, '0, res);
        check("pre lit", res, 32'h0000_1234);
        start  = 1'b1;
        bin_in = 27'd9876;
        for (int c = 1; c <= 15; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst data", data_out, 32'h0);
        check("mid rst dp", 32'(dp_ctrl), 32'h0);
        check("mid rst ovf", 32'(ovf), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            check("post rst done", 32'(done), 32'd0);
        end
        convert(27'd9876, 3'd0, "after rst", -1, '0, res);
        check("after rst lit", res, 32'h0000_9876);

        for (int n = 0; n < 1000; n++) begin
            convert(BIN_W'($urandom_range(99_999_999, 0)), 3'($urandom_range(7, 0)),
                    "rand", -1, '0, res);
        end
        tick();
        check("final done width", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
